// File: rtl/nand_stim_check.sv
// Truth-table stimulus generator and checker for a single NAND stage.
// Drives {B,A} = 00..11 for NUM_PASSES passes and counts response mismatches.
module nand_stim_check #(
  parameter int SETTLE     = 1,
  parameter int NUM_PASSES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       Nand_in,
  output logic       A,
  output logic       B,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [1:0] vec_idx
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [3:0] HOLD_INIT =
    (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
  localparam logic [7:0] LAST_PASS = 8'(NUM_PASSES - 1);
  localparam state_t     FIRST     = (SETTLE == 0) ? SAMPLE : HOLD;

  state_t     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] pcnt_q, pcnt_d;
  logic [7:0] err_q, err_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       expect_q;
  logic       mismatch;

  assign expect_q = ~(vec_q[0] & vec_q[1]);
  assign mismatch = (Nand_in != expect_q);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FIRST;
          vec_d   = 2'd0;
          cnt_d   = HOLD_INIT;
          pcnt_d  = 8'd0;
          err_d   = 8'd0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == 4'd0) state_d = SAMPLE;
        else cnt_d = cnt_q - 4'd1;
      end
      SAMPLE: begin
        if (mismatch && err_q != 8'hFF) err_d = err_q + 8'd1;
        if (vec_q == 2'd3 && pcnt_q == LAST_PASS) begin
          state_d = DONE;
          vec_d   = 2'd0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_q == 8'd0) && !mismatch;
        end else begin
          state_d = FIRST;
          vec_d   = vec_q + 2'd1;
          cnt_d   = HOLD_INIT;
          if (vec_q == 2'd3) pcnt_d = pcnt_q + 8'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= 2'd0;
      cnt_q   <= 4'd0;
      pcnt_q  <= 8'd0;
      err_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign A         = vec_q[0];
  assign B         = vec_q[1];
  assign vec_idx   = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_nand_stim_check.sv
// Bench for nand_stim_check: cycle model on a default instance plus
// two extra instances for saturation and settle-time behaviour.
module tb_nand_stim_check;

  localparam int M_S = 1;
  localparam int M_N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, start_s, start_f;
  logic [1:0] mode;
  logic chk_en = 1'b0;
  int n_vec = 0;
  int n_bad = 0;

  logic A, B, busy, done, pass, nand_m, dly_m;
  logic [7:0] err_count;
  logic [1:0] vec_idx;

  logic A_s, B_s, busy_s, done_s, pass_s;
  logic [7:0] err_s;
  logic [1:0] vec_s;

  logic A_f, B_f, busy_f, done_f, pass_f, dly_f;
  logic [7:0] err_f;
  logic [1:0] vec_f;

  // mode: 0 ideal NAND, 1 tied high, 2 tied low, 3 ideal NAND delayed 1 cycle
  always @(posedge clk) dly_m <= ~(A & B);
  always @(posedge clk) dly_f <= ~(A_f & B_f);
  assign nand_m = (mode == 2'd0) ? ~(A & B) :
                  (mode == 2'd1) ? 1'b1 :
                  (mode == 2'd2) ? 1'b0 : dly_m;

  nand_stim_check #(.SETTLE(M_S), .NUM_PASSES(M_N)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .Nand_in(nand_m),
    .A(A), .B(B), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .vec_idx(vec_idx)
  );

  nand_stim_check #(.SETTLE(0), .NUM_PASSES(100)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s), .Nand_in(1'b0),
    .A(A_s), .B(B_s), .busy(busy_s), .done(done_s), .pass(pass_s),
    .err_count(err_s), .vec_idx(vec_s)
  );

  nand_stim_check #(.SETTLE(0), .NUM_PASSES(4)) u_fast (
    .clk(clk), .rst_n(rst_n), .start(start_f), .Nand_in(dly_f),
    .A(A_f), .B(B_f), .busy(busy_f), .done(done_f), .pass(pass_f),
    .err_count(err_f), .vec_idx(vec_f)
  );

  // Model: run position counted in cycles since the accepting edge
  logic       m_run = 1'b0;
  logic       m_done = 1'b0;
  logic       m_pass = 1'b0;
  logic       m_e;
  logic [1:0] m_vec = 2'd0;
  int         m_c = 0;
  int         m_err = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_run = 0; m_c = 0; m_err = 0;
      m_pass = 0; m_done = 0; m_vec = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_run) begin
      if (start) begin
        m_run = 1; m_c = 0; m_err = 0;
        m_pass = 0; m_vec = 0;
      end
    end else begin
      m_e = ~(m_vec[0] & m_vec[1]);
      if (m_c % (M_S + 1) == M_S)
        if (nand_m !== m_e && m_err < 255) m_err++;
      m_c++;
      if (m_c == 4 * M_N * (M_S + 1)) begin
        m_run = 0; m_done = 1; m_vec = 0;
        m_pass = (m_err == 0);
      end else begin
        m_vec = 2'((m_c / (M_S + 1)) % 4);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("vec_idx", 32'(vec_idx), 32'(m_vec));
      check("A", 32'(A), 32'(m_vec[0]));
      check("B", 32'(B), 32'(m_vec[1]));
      check("busy", 32'(busy), 32'(m_run));
      check("done", 32'(done), 32'(m_done));
      check("pass", 32'(pass), 32'(m_pass));
      check("err_count", 32'(err_count), 32'(m_err));
    end
  end

  task automatic pulse(input int which);
    if (which == 0) start = 1'b1;
    else if (which == 1) start_s = 1'b1;
    else start_f = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    start_s = 1'b0;
    start_f = 1'b0;
  endtask

  task automatic wait_done(input int which, output int cyc);
    logic d;
    cyc = 0;
    while (cyc < 1000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      d = (which == 0) ? done : (which == 1) ? done_s : done_f;
      if (d) break;
    end
  endtask

  int cyc;

  initial begin
    rst_n = 1'b0; start = 1'b0; start_s = 1'b0; start_f = 1'b0;
    mode = 2'd0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err_count), 0);
    check("rst_vec", 32'(vec_idx), 0);
    check("rst_pass", 32'(pass), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ideal NAND, defaults
    mode = 2'd0;
    pulse(0);
    wait_done(0, cyc);
    check("ideal_len", 32'(cyc), 32);
    check("ideal_err", 32'(err_count), 0);
    check("ideal_pass", 32'(pass), 1);
    @(negedge clk);
    check("done_width", 32'(done), 0);
    check("idle_pass_hold", 32'(pass), 1);

    // stuck-at-1 response
    mode = 2'd1;
    pulse(0);
    wait_done(0, cyc);
    check("stuck1_len", 32'(cyc), 32);
    check("stuck1_err", 32'(err_count), 4);
    check("stuck1_pass", 32'(pass), 0);
    repeat (2) @(negedge clk);

    // reset mid-run at cycle 10
    pulse(0);
    repeat (9) @(negedge clk);
    check("pre_rst_err", 32'(err_count), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_err", 32'(err_count), 0);
    check("midrst_ab", 32'({B, A}), 0);
    repeat (3) @(negedge clk);
    mode = 2'd0;
    pulse(0);
    wait_done(0, cyc);
    check("post_rst_len", 32'(cyc), 32);
    check("post_rst_pass", 32'(pass), 1);
    repeat (2) @(negedge clk);

    // start held high across the run and DONE
    mode = 2'd1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_done(0, cyc);
    check("held_len", 32'(cyc), 32);
    check("held_err", 32'(err_count), 4);
    @(negedge clk);
    check("held_idle_busy", 32'(busy), 0);
    @(negedge clk);
    check("held_restart_busy", 32'(busy), 1);
    check("held_restart_err", 32'(err_count), 0);
    mode = 2'd0;
    start = 1'b0;
    wait_done(0, cyc);
    check("held2_len", 32'(cyc), 32);
    check("held2_pass", 32'(pass), 1);
    repeat (2) @(negedge clk);

    // delayed NAND with SETTLE=1 is tolerated
    mode = 2'd3;
    pulse(0);
    wait_done(0, cyc);
    check("dly_s1_err", 32'(err_count), 0);
    check("dly_s1_pass", 32'(pass), 1);
    repeat (2) @(negedge clk);

    // saturation: Nand_in low, SETTLE=0, 100 passes
    pulse(1);
    wait_done(1, cyc);
    check("sat_len", 32'(cyc), 400);
    check("sat_err", 32'(err_s), 255);
    check("sat_pass", 32'(pass_s), 0);
    check("sat_busy", 32'(busy_s), 0);
    repeat (2) @(negedge clk);

    // delayed NAND with SETTLE=0 misses vectors 11 and the following 00
    pulse(2);
    wait_done(2, cyc);
    check("dly_s0_len", 32'(cyc), 16);
    check("dly_s0_err", 32'(err_f), 7);
    check("dly_s0_pass", 32'(pass_f), 0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
